hazard_scoreboard: RTL and testbench

//  Parametrised successor to the single-cycle load-use hazard unit. Tracks every
//  in-flight long-latency writer in a per-register countdown scoreboard:

---
 rtl/hazard_scoreboard_if.sv | 56 +++++
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
//   Bundles the decode-side hazard query, issue and writeback inputs with the
//   stall and pending outputs of the hazard scoreboard.
//   master : pipeline side (drives the query/issue/writeback, observes stalls)
//   slave  : scoreboard side
//   Signals
//     IF_ID_rs1/IF_ID_rs2/opcode        decoding instruction sources + opcode[6:4]
//     issue_valid/long/rd/lat           instruction leaving ID for EX
//     wb_valid/wb_rd                    early or variable-latency result ready
//     PC_Stall/IF_ID_Stall/Mux_Sel_Flush  stall and bubble controls
//     pending                           per-register busy vector
//     stall_count                       hazard-cycle counter (HAZARD_PERF_CNT_EN)
interface hazard_scoreboard_if #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned LAT_W      = 3,
   parameter int unsigned CNT_W      = 32
);
   localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

   logic [REG_ADDR_W-1:0] IF_ID_rs1;
   logic [REG_ADDR_W-1:0] IF_ID_rs2;
   logic [2:0]            opcode;
   logic                  issue_valid;
   logic                  issue_long;
   logic [REG_ADDR_W-1:0] issue_rd;
   logic [LAT_W-1:0]      issue_lat;
   logic                  wb_valid;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  PC_Stall;
   logic                  IF_ID_Stall;
   logic                  Mux_Sel_Flush;
   logic [NUM_REGS-1:0]   pending;
`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0]      stall_count;
`endif

   modport master (
      output IF_ID_rs1, IF_ID_rs2, opcode,
      output issue_valid, issue_long, issue_rd, issue_lat,
      output wb_valid, wb_rd,
      input  PC_Stall, IF_ID_Stall, Mux_Sel_Flush, pending
`ifdef HAZARD_PERF_CNT_EN
      , input stall_count
`endif
   );

   modport slave (
      input  IF_ID_rs1, IF_ID_rs2, opcode,
      input  issue_valid, issue_long, issue_rd, issue_lat,
      input  wb_valid, wb_rd,
      output PC_Stall, IF_ID_Stall, Mux_Sel_Flush, pending
`ifdef HAZARD_PERF_CNT_EN
      , output stall_count
`endif
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Per-register countdown scoreboard for long-latency writers. Fixed-latency
//   writers count down to zero; a latency of all-ones holds the entry until an
//   explicit writeback clears it. While any used source of the decoding
//   instruction is pending, PC and IF/ID are held and a bubble goes into ID/EX.
//   Ports
//     CLK    rising-edge clock
//     rst_n  asynchronous active-low reset (empties the scoreboard)
//     hif    hazard_scoreboard_if.slave (query, issue, writeback, stalls, pending)
//   Optional feature: define HAZARD_PERF_CNT_EN to add hif.stall_count, a
//   saturating count of hazard cycles.
//   Stall outputs are combinational from the registered scoreboard so the
//   decoding instruction is held in the same cycle its hazard appears.
module hazard_scoreboard #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned LAT_W      = 3,
   parameter int unsigned CNT_W      = 32
) (
   input logic                CLK,
   input logic                rst_n,
   hazard_scoreboard_if.slave hif
);
   localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
   localparam logic [LAT_W-1:0] LAT_HOLD = '1;

   logic [LAT_W-1:0] cnt_q [NUM_REGS];
   logic [LAT_W-1:0] cnt_d [NUM_REGS];

   logic                use1_c;
   logic                use2_c;
   logic                hazard_c;
   logic                accept_c;
   logic [NUM_REGS-1:0] pending_c;

   // Which source fields the decoding opcode actually reads
   always_comb begin
      use1_c = (hif.opcode != 3'b111);
      use2_c = (hif.opcode == 3'b010) || (hif.opcode == 3'b011) ||
               (hif.opcode == 3'b110);
   end

   // Hazard detect; x0 is never busy
   always_comb begin
      hazard_c = 1'b0;
      if (use1_c && (hif.IF_ID_rs1 != '0) && (cnt_q[hif.IF_ID_rs1] != '0))
         hazard_c = 1'b1;
      if (use2_c && (hif.IF_ID_rs2 != '0) && (cnt_q[hif.IF_ID_rs2] != '0))
         hazard_c = 1'b1;
   end

   // A stalled instruction is replaced by a bubble, so its issue is ignored
   always_comb begin
      accept_c = hif.issue_valid && !hazard_c && hif.issue_long &&
                 (hif.issue_rd != '0) && (hif.issue_lat != '0);
   end

   // Per-register next count: issue beats writeback beats countdown
   always_comb begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (r == 0) begin
            cnt_d[r] = '0;
         end else if (accept_c && (hif.issue_rd == REG_ADDR_W'(r))) begin
            cnt_d[r] = hif.issue_lat;
         end else if (hif.wb_valid && (hif.wb_rd == REG_ADDR_W'(r))) begin
            cnt_d[r] = '0;
         end else if ((cnt_q[r] != '0) && (cnt_q[r] != LAT_HOLD)) begin
            cnt_d[r] = cnt_q[r] - LAT_W'(1);
         end
      end
   end

   // Scoreboard state
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   // Busy vector
   always_comb begin
      pending_c = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         pending_c[r] = (cnt_q[r] != '0);
      end
   end

   assign hif.PC_Stall      = hazard_c;
   assign hif.IF_ID_Stall   = hazard_c;
   assign hif.Mux_Sel_Flush = hazard_c;
   assign hif.pending       = pending_c;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_count_q;
   logic [CNT_W-1:0] stall_count_d;

   // Saturating hazard-cycle counter
   always_comb begin
      stall_count_d = stall_count_q;
      if (hazard_c && (stall_count_q != '1))
         stall_count_d = stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) stall_count_q <= '0;
      else        stall_count_q <= stall_count_d;
   end

   assign hif.stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned LAT_W      = 3;
   localparam int unsigned CNT_W      = 32;
   localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_pass;
   int   stall_cycles;
   logic [2:0] stalls;

   hazard_scoreboard_if #(.REG_ADDR_W(REG_ADDR_W), .LAT_W(LAT_W), .CNT_W(CNT_W)) hif ();

   hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
      .CLK   (clk),
      .rst_n (rst_n),
      .hif   (hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign stalls = {hif.PC_Stall, hif.IF_ID_Stall, hif.Mux_Sel_Flush};

   // Advance one clock: inputs change at negedge, checks at negedge+1
   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      hif.IF_ID_rs1   = '0;
      hif.IF_ID_rs2   = '0;
      hif.opcode      = 3'b000;
      hif.issue_valid = 1'b0;
      hif.issue_long  = 1'b0;
      hif.issue_rd    = '0;
      hif.issue_lat   = '0;
      hif.wb_valid    = 1'b0;
      hif.wb_rd       = '0;
   endtask

   task automatic set_issue(input logic [REG_ADDR_W-1:0] rd, input logic [LAT_W-1:0] lat);
      hif.issue_valid = 1'b1;
      hif.issue_long  = 1'b1;
      hif.issue_rd    = rd;
      hif.issue_lat   = lat;
   endtask

   task automatic clr_issue();
      hif.issue_valid = 1'b0;
      hif.issue_long  = 1'b0;
      hif.issue_rd    = '0;
      hif.issue_lat   = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      hif.IF_ID_rs1 = 5'd5;
      hif.IF_ID_rs2 = 5'd5;
      hif.opcode    = 3'b110;
      #1;
      n_total++;
      if (stalls !== 3'b000) $display("FAIL reset_stall_during got=%b exp=000", stalls);
      else n_pass++;
      n_total++;
      if (hif.pending !== 32'h0) $display("FAIL reset_pending got=%h exp=0", hif.pending);
      else n_pass++;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      n_total++;
      if (stalls !== 3'b000) $display("FAIL reset_stall_after got=%b exp=000", stalls);
      else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
      n_total++;
      if (hif.stall_count !== 32'd0) $display("FAIL reset_perf got=%0d exp=0", hif.stall_count);
      else n_pass++;
`endif
   endtask

   task automatic test_lat1();
      idle_inputs();
      set_issue(5'd5, 3'd1);
      next_cycle();
      clr_issue();
      hif.IF_ID_rs1 = 5'd5;
      hif.opcode    = 3'b000;
      #1;
      n_total++;
      if (stalls !== 3'b111) $display("FAIL lat1_stall got=%b exp=111", stalls);
      else n_pass++;
      n_total++;
      if (hif.pending !== 32'h0000_0020) $display("FAIL lat1_pending got=%h exp=00000020", hif.pending);
      else n_pass++;
      next_cycle();
      n_total++;
      if (stalls !== 3'b000) $display("FAIL lat1_release got=%b exp=000", stalls);
      else n_pass++;
   endtask

   task automatic test_lat4_uses();
      idle_inputs();
      set_issue(5'd10, 3'd4);
      hif.opcode = 3'b011;
      next_cycle();
      clr_issue();
      hif.IF_ID_rs2 = 5'd10;
      #1;
      stall_cycles = 0;
      for (int i = 0; i < 8; i++) begin
         if (stalls == 3'b111) stall_cycles++;
         // A long issue during the stall must be squashed
         if (i == 1) set_issue(5'd6, 3'd3);
         else        clr_issue();
         next_cycle();
      end
      n_total++;
      if (stall_cycles !== 4) $display("FAIL lat4_stall_len got=%0d exp=4", stall_cycles);
      else n_pass++;
      n_total++;
      if (hif.pending !== 32'h0) $display("FAIL squashed_issue_pending got=%h exp=0", hif.pending);
      else n_pass++;
      // Re-issue and probe source-use decoding
      idle_inputs();
      set_issue(5'd10, 3'd4);
      next_cycle();
      clr_issue();
      hif.opcode = 3'b111; hif.IF_ID_rs1 = 5'd10; hif.IF_ID_rs2 = 5'd10;
      #1;
      n_total++;
      if (stalls !== 3'b000) $display("FAIL op111_no_stall got=%b exp=000", stalls);
      else n_pass++;
      hif.opcode = 3'b000; hif.IF_ID_rs1 = 5'd0; hif.IF_ID_rs2 = 5'd10;
      #1;
      n_total++;
      if (stalls !== 3'b000) $display("FAIL op000_rs2_unused got=%b exp=000", stalls);
      else n_pass++;
      hif.opcode = 3'b010;
      #1;
      n_total++;
      if (stalls !== 3'b111) $display("FAIL store_rs2_stall got=%b exp=111", stalls);
      else n_pass++;
      for (int i = 0; i < 4; i++) next_cycle();
      n_total++;
      if (hif.pending !== 32'h0) $display("FAIL lat4_drained got=%h exp=0", hif.pending);
      else n_pass++;
   endtask

   task automatic test_hold_wb();
      idle_inputs();
      set_issue(5'd31, 3'd7);
      next_cycle();
      clr_issue();
      hif.IF_ID_rs1 = 5'd31;
      #1;
      stall_cycles = 0;
      for (int i = 0; i < 22; i++) begin
         if (stalls == 3'b111) stall_cycles++;
         next_cycle();
      end
      n_total++;
      if (stall_cycles !== 22) $display("FAIL hold_stall_len got=%0d exp=22", stall_cycles);
      else n_pass++;
      hif.wb_valid = 1'b1;
      hif.wb_rd    = 5'd31;
      #1;
      n_total++;
      if (stalls !== 3'b111) $display("FAIL hold_wb_same_cycle got=%b exp=111", stalls);
      else n_pass++;
      next_cycle();
      hif.wb_valid = 1'b0;
      #1;
      n_total++;
      if (stalls !== 3'b000) $display("FAIL hold_wb_release got=%b exp=000", stalls);
      else n_pass++;
      n_total++;
      if (hif.pending !== 32'h0) $display("FAIL hold_wb_pending got=%h exp=0", hif.pending);
      else n_pass++;
   endtask

   task automatic test_priority();
      idle_inputs();
      // Issue wins over writeback on the same register and edge
      set_issue(5'd3, 3'd2);
      hif.wb_valid = 1'b1;
      hif.wb_rd    = 5'd3;
      next_cycle();
      clr_issue();
      hif.wb_valid = 1'b0;
      hif.IF_ID_rs1 = 5'd3;
      #1;
      stall_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         if (stalls == 3'b111) stall_cycles++;
         next_cycle();
      end
      n_total++;
      if (stall_cycles !== 2) $display("FAIL issue_beats_wb got=%0d exp=2", stall_cycles);
      else n_pass++;
      idle_inputs();
      set_issue(5'd0, 3'd3);
      next_cycle();
      clr_issue();
      n_total++;
      if (hif.pending !== 32'h0) $display("FAIL issue_x0 got=%h exp=0", hif.pending);
      else n_pass++;
      hif.issue_valid = 1'b1; hif.issue_long = 1'b0; hif.issue_rd = 5'd8; hif.issue_lat = 3'd3;
      next_cycle();
      hif.issue_long = 1'b1; hif.issue_lat = 3'd0;
      next_cycle();
      clr_issue();
      n_total++;
      if (hif.pending !== 32'h0) $display("FAIL short_or_lat0 got=%h exp=0", hif.pending);
      else n_pass++;
      // WAW: newest latency overwrites
      set_issue(5'd4, 3'd6);
      next_cycle();
      set_issue(5'd4, 3'd1);
      next_cycle();
      clr_issue();
      n_total++;
      if (hif.pending !== 32'h0000_0010) $display("FAIL waw_pending got=%h exp=00000010", hif.pending);
      else n_pass++;
      next_cycle();
      n_total++;
      if (hif.pending !== 32'h0) $display("FAIL waw_overwrite got=%h exp=0", hif.pending);
      else n_pass++;
      // Writeback clears a fixed entry early
      set_issue(5'd7, 3'd5);
      next_cycle();
      clr_issue();
      hif.wb_valid = 1'b1; hif.wb_rd = 5'd7;
      next_cycle();
      hif.wb_valid = 1'b0;
      n_total++;
      if (hif.pending !== 32'h0) $display("FAIL wb_clears_fixed got=%h exp=0", hif.pending);
      else n_pass++;
   endtask

   task automatic test_perf_cnt();
`ifdef HAZARD_PERF_CNT_EN
      do_reset();
      set_issue(5'd9, 3'd3);
      next_cycle();
      clr_issue();
      hif.IF_ID_rs1 = 5'd9;
      for (int i = 0; i < 5; i++) next_cycle();
      n_total++;
      if (hif.stall_count !== 32'd3) $display("FAIL perf_count got=%0d exp=3", hif.stall_count);
      else n_pass++;
      idle_inputs();
`endif
   endtask

   task automatic test_reset_mid_stall();
      idle_inputs();
      set_issue(5'd20, 3'd7);
      next_cycle();
      clr_issue();
      hif.IF_ID_rs1 = 5'd20;
      next_cycle();
      next_cycle();
      n_total++;
      if (stalls !== 3'b111) $display("FAIL pre_reset_stall got=%b exp=111", stalls);
      else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_total++;
      if (stalls !== 3'b000) $display("FAIL async_reset_stall got=%b exp=000", stalls);
      else n_pass++;
      n_total++;
      if (hif.pending !== 32'h0) $display("FAIL async_reset_pending got=%h exp=0", hif.pending);
      else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
      n_total++;
      if (hif.stall_count !== 32'd0) $display("FAIL async_reset_perf got=%0d exp=0", hif.stall_count);
      else n_pass++;
`endif
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      n_total++;
      if (stalls !== 3'b000) $display("FAIL post_reset_stall got=%b exp=000", stalls);
      else n_pass++;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst_n   = 1'b0;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_lat1();
      test_lat4_uses();
      test_hold_wb();
      test_priority();
      test_perf_cnt();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
